mmio_uart_tx: RTL

//  Memory-mapped UART transmitter on the processor store path, downstream of the memory's write port.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 54 +++++
 rtl/mmio_uart_tx.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and register map for the memory-mapped UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam logic [31:0] TXDATA_OFS = 32'd0;
    localparam logic [31:0] STATUS_OFS = 32'd4;

    localparam int unsigned ST_FULL   = 0;
    localparam int unsigned ST_EMPTY  = 1;
    localparam int unsigned ST_BUSY   = 2;
    localparam int unsigned ST_OVF    = 3;
    localparam int unsigned ST_CNT_LO = 4;
    localparam int unsigned ST_CNT_HI = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead output; a push while full is accepted only alongside a pop.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA store queues a byte, STATUS load reports FIFO/line state.
// Define UART_TX_PARITY_EN to send an even-parity bit (8E1); otherwise frames are 8N1.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 12000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write_mem,
    input  logic [2:0]  funct3,
    input  logic [31:0] write_address,
    input  logic [31:0] write_data,
    input  logic [31:0] read_address,
    output logic [31:0] read_data,
    output logic        tx,
    output logic        tx_busy
);

    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned CW           = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    uart_state_t      state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             overflow;
`ifdef UART_TX_PARITY_EN
    logic             parity_bit;
`endif

    logic             wr_tx;
    logic             wr_status;
    logic             fifo_pop;
    logic [7:0]       fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic [31:0]      status;
    logic             unused_bits;

    assign unused_bits = ^{funct3, write_data[31:8]};

    assign wr_tx     = write_mem && (write_address == BASE_ADDR + TXDATA_OFS);
    assign wr_status = write_mem && (write_address == BASE_ADDR + STATUS_OFS);
    assign fifo_pop  = (state == IDLE) && !fifo_empty;
    assign tx_busy   = (state != IDLE) || !fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_tx),
        .pop   (fifo_pop),
        .din   (write_data[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // A full FIFO still accepts the store when the FSM pops in the same cycle.
    always_ff @(posedge clk) begin
        if (reset)
            overflow <= 1'b0;
        else if (wr_tx && fifo_full && !fifo_pop)
            overflow <= 1'b1;
        else if (wr_status)
            overflow <= 1'b0;
    end

    always_comb begin
        status                      = '0;
        status[ST_FULL]             = fifo_full;
        status[ST_EMPTY]            = fifo_empty;
        status[ST_BUSY]             = tx_busy;
        status[ST_OVF]              = overflow;
        status[ST_CNT_HI:ST_CNT_LO] = 5'(fifo_count);
    end

    always_ff @(posedge clk) begin
        if (reset)
            read_data <= '0;
        else if (read_address == BASE_ADDR + STATUS_OFS)
            read_data <= status;
        else
            read_data <= '0;
    end

    // tx is registered and loaded with the next bit at each bit boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    if (!fifo_empty) begin
                        shift <= fifo_dout;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^fifo_dout;
`endif
                        tx    <= 1'b0;
                        state <= START;
                    end else begin
                        tx <= 1'b1;
                    end
                end
                START: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= shift[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx    <= parity_bit;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shift   <= {1'b0, shift[7:1]};
                            tx      <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        tx       <= 1'b1;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        tx       <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    baud_cnt <= '0;
                    tx       <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
